// File: rtl/fpcvt.sv
// Free-running modulo counter: steps by STEP every clock, wraps modulo MAX_VAL+1,
// counts up or down, and drives its output straight from the state register.
module fpcvt #(
    parameter int WIDTH     = 3,
    parameter int MAX_VAL   = 7,
    parameter int STEP      = 1,
    parameter bit DOWN      = 1'b0,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out
);

    // Bad parameter sets stop elaboration instead of producing a silently wrong counter.
    if (WIDTH < 1 || MAX_VAL < 0 || longint'(MAX_VAL) > (longint'(1) << WIDTH) - 1) begin : g_bad_range
        $fatal(1, "fpcvt: MAX_VAL does not fit in WIDTH bits");
    end
    if (STEP < 1 || STEP > MAX_VAL) begin : g_bad_step
        $fatal(1, "fpcvt: STEP must satisfy 1 <= STEP <= MAX_VAL");
    end
    if (RESET_VAL < 0 || RESET_VAL > MAX_VAL) begin : g_bad_reset
        $fatal(1, "fpcvt: RESET_VAL must satisfy 0 <= RESET_VAL <= MAX_VAL");
    end

    // One extra bit so MAX_VAL+1 (up to 2**WIDTH) and the pre-wrap sum are representable.
    localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MAX_VAL + 1);
    localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH:0]   cur_ext;
    logic [WIDTH:0]   nxt;
    logic             unused_nxt_msb;

    // NOTE: every signal written here is given a default first, so no latch is inferred.
    always_comb begin
        cur_ext = {1'b0, out_q};
        nxt     = cur_ext;
        if (DOWN) begin
            if (cur_ext >= STEP_W) nxt = cur_ext - STEP_W;
            else                   nxt = cur_ext + MOD_W - STEP_W;
        end else begin
            nxt = cur_ext + STEP_W;
            if (nxt > MAX_W) nxt = nxt - MOD_W;
        end
        out_d = nxt[WIDTH-1:0];
    end

    assign unused_nxt_msb = nxt[WIDTH];

    // NOTE: state flops use non-blocking assignment so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) out_q <= RST_W;
        else     out_q <= out_d;
    end

    assign out = out_q;

endmodule

// File: tb/tb_fpcvt.sv
// Directed bench for fpcvt: five parameterisations share one clock and reset,
// each checked against hand-derived sequences after every edge.
module tb_fpcvt;

    logic       clk;
    logic       rst;
    logic [2:0] out_def;
    logic [2:0] out_s2;
    logic [2:0] out_s2m6;
    logic [2:0] out_dn;
    logic [7:0] out_w8;

    int n_checks = 0;
    int n_errors = 0;

    // Up-sequences after release from 0 for the two step-2 counters.
    int seq_m5[3] = '{2, 4, 0};
    int seq_m6[7] = '{2, 4, 6, 1, 3, 5, 0};

    fpcvt u_def (.clk(clk), .rst(rst), .out(out_def));
    fpcvt #(.WIDTH(3), .MAX_VAL(5), .STEP(2)) u_s2 (.clk(clk), .rst(rst), .out(out_s2));
    fpcvt #(.WIDTH(3), .MAX_VAL(6), .STEP(2)) u_s2m6 (.clk(clk), .rst(rst), .out(out_s2m6));
    fpcvt #(.DOWN(1'b1), .RESET_VAL(7)) u_dn (.clk(clk), .rst(rst), .out(out_dn));
    fpcvt #(.WIDTH(8), .MAX_VAL(255), .RESET_VAL(250)) u_w8 (.clk(clk), .rst(rst), .out(out_w8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d", tag, got, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " def"},  32'(out_def),  32'd0);
        check({tag, " s2"},   32'(out_s2),   32'd0);
        check({tag, " s2m6"}, 32'(out_s2m6), 32'd0);
        check({tag, " dn"},   32'(out_dn),   32'd7);
        check({tag, " w8"},   32'(out_w8),   32'd250);
    endtask

    // k = number of non-reset edges since rst fell.
    task automatic check_run(input string tag, input int k);
        check({tag, " def"},  32'(out_def),  32'(k % 8));
        check({tag, " s2"},   32'(out_s2),   32'(seq_m5[(k - 1) % 3]));
        check({tag, " s2m6"}, 32'(out_s2m6), 32'(seq_m6[(k - 1) % 7]));
        check({tag, " dn"},   32'(out_dn),   32'((15 - (k % 8)) % 8));
        check({tag, " w8"},   32'(out_w8),   32'((250 + k) % 256));
        check({tag, " w8 known"}, 32'($isunknown(out_w8)), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            check_reset_vals("hold_rst");
        end

        @(negedge clk) rst = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk); #1;
            check_run("run", k);
        end
        check("mid def at 5", 32'(out_def), 32'd5);

        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("mid_rst");

        @(negedge clk) rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            check_run("resume", k);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
